// File: rtl/int_to_fp.sv
// Iterative 32-bit integer to IEEE-754 single-precision converter with round-to-nearest-even.
// Define INT_TO_FP_INEXACT_EN to add the out_inexact flag port.
module int_to_fp #(
  parameter int unsigned NORM_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
`ifdef INT_TO_FP_INEXACT_EN
  ,
  output logic        out_inexact
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam logic [EW-1:0] EXP_INIT = 8'd158;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mag;
  logic [EW-1:0]   r_exp;
  logic            r_sign;
  logic [DW-1:0]   r_out;
  logic            r_out_valid;
  logic            r_in_ready;

  state_t          w_state_next;
  logic [DW-1:0]   w_mag_next;
  logic [EW-1:0]   w_exp_next;
  logic            w_sign_next;
  logic [DW-1:0]   w_out_next;
  logic            w_out_valid_next;
  logic            w_in_ready_next;

  logic [DW-1:0]   w_mag_abs;
  logic            w_top_zero;
  logic            w_guard;
  logic            w_sticky;
  logic            w_round_up;
  logic [MW:0]     w_mant_rnd;

`ifdef INT_TO_FP_INEXACT_EN
  logic            r_inexact;
  logic            w_inexact_next;
  assign out_inexact = r_inexact;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;

  // Rounding fields taken from the normalized magnitude (leading one at bit 31).
  assign w_mag_abs  = r_sign ? (~r_mag + 32'd1) : r_mag;
  assign w_top_zero = (r_mag[DW-1 -: NORM_STEP] == '0);
  assign w_guard    = r_mag[7];
  assign w_sticky   = |r_mag[6:0];
  assign w_round_up = w_guard & (w_sticky | r_mag[8]);
  assign w_mant_rnd = {1'b0, r_mag[30:8]} + 24'(w_round_up);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mag       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef INT_TO_FP_INEXACT_EN
      r_inexact   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_mag       <= w_mag_next;
      r_exp       <= w_exp_next;
      r_sign      <= w_sign_next;
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
      r_in_ready  <= w_in_ready_next;
`ifdef INT_TO_FP_INEXACT_EN
      r_inexact   <= w_inexact_next;
`endif
    end
  end

  // out_valid trails entry into DONE by one cycle and drops on the handshake.
  always_comb begin
    w_state_next = r_state;
    w_mag_next   = r_mag;
    w_exp_next   = r_exp;
    w_sign_next  = r_sign;
    w_out_next   = r_out;
`ifdef INT_TO_FP_INEXACT_EN
    w_inexact_next = r_inexact;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_mag_next   = in_data;
          w_sign_next  = in_signed & in_data[31];
          w_exp_next   = EXP_INIT;
          w_state_next = S_ABS;
        end
      end
      S_ABS: begin
        w_mag_next = w_mag_abs;
        if (w_mag_abs == '0) begin
          w_out_next   = '0;
`ifdef INT_TO_FP_INEXACT_EN
          w_inexact_next = 1'b0;
`endif
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_NORM;
        end
      end
      S_NORM: begin
        if (r_mag[DW-1]) begin
          w_state_next = S_ROUND;
        end else if (w_top_zero) begin
          w_mag_next = r_mag << NORM_STEP;
          w_exp_next = r_exp - 8'(NORM_STEP);
        end else begin
          w_mag_next = r_mag << 1;
          w_exp_next = r_exp - 8'd1;
        end
      end
      S_ROUND: begin
        w_out_next   = {r_sign, r_exp + 8'(w_mant_rnd[MW]), w_mant_rnd[MW-1:0]};
`ifdef INT_TO_FP_INEXACT_EN
        w_inexact_next = w_guard | w_sticky;
`endif
        w_state_next = S_DONE;
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    w_out_valid_next = (r_state == S_DONE) && !(r_out_valid && out_ready);
    w_in_ready_next  = (w_state_next == S_IDLE);
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed vector table, hand sequences and a random sweep
// against an arithmetic float-conversion model.
module tb_int_to_fp;

  localparam int unsigned STEP = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
`ifdef INT_TO_FP_INEXACT_EN
  logic        out_inexact;
`endif

  int checks   = 0;
  int failures = 0;

  int_to_fp #(.NORM_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef INT_TO_FP_INEXACT_EN
    ,
    .out_inexact (out_inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic [31:0] f;
    logic        inx;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact real-number rounding of the integer value, plus cycle count of the shifter.
  function automatic void model(input logic [31:0] d, input logic s,
                                output logic [31:0] f, output logic inx, output int lat);
    longint mag, q, rem, half, one;
    int p, lz, sh;
    logic sg;
    one = 1;
    sg  = s & d[31];
    mag = {32'h0, d};
    if (sg) mag = (one << 32) - mag;
    if (mag == 0) begin
      f = 32'h0; inx = 1'b0; lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    lz  = 31 - p;
    lat = 3 + lz / int'(STEP) + lz % int'(STEP) + 1;
    rem = 0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag % (one << sh);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q % 2 == 1)) q = q + 1;
      if (q == (one << 24)) begin
        q = q / 2;
        p = p + 1;
      end
    end
    f   = {sg, 8'(127 + p), 23'(q)};
    inx = (rem != 0);
  endfunction

  // Drive one accept; caller is #1 after a rising edge with the DUT idle.
  task automatic start(input logic [31:0] d, input logic s);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_signed = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] d, input logic s,
                         input logic [31:0] f, input logic inx, input int lat);
    int got_lat;
    start(d, s);
    wait_valid(got_lat);
    chk({tag, "_latency"}, 32'(got_lat), 32'(lat));
    chk({tag, "_out"}, out, f);
`ifdef INT_TO_FP_INEXACT_EN
    chk({tag, "_inexact"}, 32'(out_inexact), 32'(inx));
`else
    if (inx === 1'bx) $display("inexact flag unknown for %s", tag);
`endif
    handshake();
  endtask

  vec_t tbl[11];

  initial begin
    logic [31:0] d, f, held;
    logic        s, inx;
    int          lat, seen;

    tbl[0]  = '{32'h00000001, 1'b1, 32'h3F800000, 1'b0, 14};
    tbl[1]  = '{32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 14};
    tbl[2]  = '{32'h80000000, 1'b1, 32'hCF000000, 1'b0, 4};
    tbl[3]  = '{32'h80000000, 1'b0, 32'h4F000000, 1'b0, 4};
    tbl[4]  = '{32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b1, 4};
    tbl[5]  = '{32'h01000001, 1'b0, 32'h4B800000, 1'b1, 8};
    tbl[6]  = '{32'h01000003, 1'b0, 32'h4B800002, 1'b1, 8};
    tbl[7]  = '{32'h00FFFFFF, 1'b0, 32'h4B7FFFFF, 1'b0, 6};
    tbl[8]  = '{32'h00000000, 1'b1, 32'h00000000, 1'b0, 2};
    tbl[9]  = '{32'h00000000, 1'b0, 32'h00000000, 1'b0, 2};
    tbl[10] = '{32'hFFFFFFFE, 1'b0, 32'h4F800000, 1'b1, 4};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", out, 32'h0);

    foreach (tbl[i]) run_one($sformatf("vec%0d", i), tbl[i].d, tbl[i].s, tbl[i].f, tbl[i].inx, tbl[i].lat);

    // Reset while normalizing aborts the conversion.
    start(32'h00000001, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midreset_no_valid", 32'(seen), 32'd0);
    chk("midreset_out", out, 32'h0);

    // Backpressure: output held, new requests refused, then back-to-back conversion.
    start(32'h01000003, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd8);
    held = out;
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    in_signed = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_stable", out, held);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    chk("bp_out_value", held, 32'h4B800002);
    handshake();
    in_valid = 1'b0;
    model(32'hFFFFFF85, 1'b1, f, inx, lat);
    run_one("b2b", 32'hFFFFFF85, 1'b1, f, inx, lat);

    // Random sweep with leading-zero spread and small negatives.
    for (int n = 0; n < 150; n++) begin
      d = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) d = ~d + 32'd1;
      if ($urandom_range(0, 29) == 0) d = 32'h0;
      model(d, s, f, inx, lat);
      run_one($sformatf("rnd%0d_%h_%0d", n, d, s), d, s, f, inx, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
